ssd_scan_driver: RTL and testbench
==================================

// Module: ssd_scan_driver
// PURPOSE
//  Parametrised N-digit seven-segment scan driver with tear-free frame loading,
//  per-digit decimal points and blanking, and PWM brightness control.
//  Sits in the top level between the game/status logic and the An*/Ca..Cg/Dp
//  pins. Replaces the inline hard-wired 8-digit mux and hex decoder.
// PARAMETERS
//  NUM_DIGITS     8   digits driven, 1..16; an width and scan wrap point
//  SCAN_DIV_BITS  14  prescaler width; one digit slot = 2^SCAN_DIV_BITS clocks
//  PWM_BITS       4   brightness resolution; must be < SCAN_DIV_BITS
// PORTS
//  board_clk   in   1               100 MHz system clock
//  Reset       in   1               async, active-high
//  load        in   1               1-cycle pulse: capture digits_in/dp_in/blank_in/brightness
//  digits_in   in   4*NUM_DIGITS    hex nibble per digit; digit i = [4i+3:4i]
//  dp_in       in   NUM_DIGITS      1 = decimal point lit on digit i
//  blank_in    in   NUM_DIGITS      1 = digit i forced dark
//  brightness  in   PWM_BITS        duty select; all-ones = full on
//  an          out  NUM_DIGITS      anodes, active-low
//  cathodes    out  8               {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low
//  frame_done  out  1               1-cycle pulse when scan wraps to digit 0
// BEHAVIOUR
//  - Reset (async, active-high; clock board_clk): prescaler=0, idx=0, active and
//    pending registers=0, pending_valid=0, an=all ones, cathodes=8'hFF, frame_done=0.
//  - Prescaler: free-running SCAN_DIV_BITS counter; tick = prescaler all ones.
//    On tick idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1. Non-power-of-2 wraps explicitly.
//  - frame_done registered: asserted the cycle after the tick that wraps idx to 0.
//  - Load path: load captures inputs into pending, sets pending_valid. At a wrap
//    tick, if pending_valid: active <= pending, pending_valid <= 0. load on the
//    same cycle as a wrap tick: inputs copied straight to active, pending_valid
//    left 0. load twice before wrap: last one wins. Display never mixes frames.
//  - Phase = prescaler[SCAN_DIV_BITS-1 -: PWM_BITS]. Digit enabled iff
//    phase <= active_brightness and not blanked. brightness=0 -> 1/2^PWM_BITS duty.
//  - Outputs registered: an/cathodes reflect idx/prescaler of previous cycle
//    (1-cycle latency). Enabled: an = ~(1<<idx); else an = all ones and
//    cathodes = 8'hFF (no ghosting).
//  - Decode abcdefg (0=lit): 0:0000001 1:1001111 2:0010010 3:0000110 4:1001100
//    5:0100100 6:0100000 7:0001111 8:0000000 9:0000100 A:0001000 B:1100000
//    C:0110001 D:1000010 E:0110000 F:0111000. Dp pin = ~active_dp[idx].
//  - Reset mid-frame: outputs go dark immediately; scan restarts at digit 0.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: digits above the most significant nonzero
//    active digit are blanked (digit 0 never auto-blanked; all-zero shows "0").
//    A digit with active_dp set is never auto-blanked. Computed from active regs.
//  Undefined: only blank_in blanks; zeros displayed on every digit.
// TESTING (NUM_DIGITS=8, SCAN_DIV_BITS=4, PWM_BITS=2)
//  1 Hold Reset, release -> an=8'hFF, cathodes=8'hFF until first enabled slot.
//  2 load digits 32'h0000_00A5, dp=0, blank=0, brightness=2'b11, wait one frame
//    -> an steps FE,FD,...,7F every 16 clks; digit0 cathodes=8'b01001001,
//    digit1 8'b00010001, digits2..7 8'b00000011; frame_done 1 clk per 128.
//  3 load 32'h1111_1111 mid-frame -> remaining slots still old data; new data from
//    digit 0 after wrap; load at wrap-tick cycle -> new data immediately.
//  4 brightness=2'b00 -> per 16-clk slot, an low exactly 4 clks; 2'b01 -> 8 clks.
//  5 blank_in=8'h02, dp_in=8'h01 -> an[1] never low; digit0 Dp bit=0.
//  6 digits 32'h0000_0105: with LEADING_ZERO_BLANK_EN digits 3..7 dark, digit1
//    shows 0; without macro all 8 lit.

Source files
------------

// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - N-digit seven-segment scan driver with tear-free loading and PWM dimming
// Optional feature macro: LEADING_ZERO_BLANK_EN (auto-blank leading zero digits)
module ssd_scan_driver #(
    parameter int NUM_DIGITS    = 8,
    parameter int SCAN_DIV_BITS = 14,
    parameter int PWM_BITS      = 4
) (
    input  logic                    board_clk,
    input  logic                    Reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [PWM_BITS-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              cathodes,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // Scan position
    logic [SCAN_DIV_BITS-1:0] presc_q, presc_d;
    logic [IDX_W-1:0]         idx_q, idx_d;

    // Frame currently on the glass and frame waiting for the next wrap
    logic [4*NUM_DIGITS-1:0]  act_dig_q, pend_dig_q;
    logic [NUM_DIGITS-1:0]    act_dp_q, pend_dp_q;
    logic [NUM_DIGITS-1:0]    act_blank_q, pend_blank_q;
    logic [PWM_BITS-1:0]      act_bright_q, pend_bright_q;
    logic                     pend_valid_q;

    // Registered pin drive
    logic [NUM_DIGITS-1:0]    an_q, an_d;
    logic [7:0]               cath_q, cath_d;
    logic                     fd_q;

    logic                     tick;
    logic                     wrap;
    logic [PWM_BITS-1:0]      phase;
    logic [3:0]               cur_nib;
    logic                     cur_dp;
    logic                     cur_blank;
    logic                     enabled;
    logic [NUM_DIGITS-1:0]    lz_blank;

    // Active-low abcdefg pattern for a hex nibble
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0: seg_decode = 7'b0000001;
            4'h1: seg_decode = 7'b1001111;
            4'h2: seg_decode = 7'b0010010;
            4'h3: seg_decode = 7'b0000110;
            4'h4: seg_decode = 7'b1001100;
            4'h5: seg_decode = 7'b0100100;
            4'h6: seg_decode = 7'b0100000;
            4'h7: seg_decode = 7'b0001111;
            4'h8: seg_decode = 7'b0000000;
            4'h9: seg_decode = 7'b0000100;
            4'hA: seg_decode = 7'b0001000;
            4'hB: seg_decode = 7'b1100000;
            4'hC: seg_decode = 7'b0110001;
            4'hD: seg_decode = 7'b1000010;
            4'hE: seg_decode = 7'b0110000;
            default: seg_decode = 7'b0111000;
        endcase
    endfunction

    assign tick  = &presc_q;
    assign wrap  = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign phase = presc_q[SCAN_DIV_BITS-1 -: PWM_BITS];

    // Next scan position; idx wraps explicitly so non-power-of-2 digit counts work
    always_comb begin
        presc_d = presc_q + SCAN_DIV_BITS'(1);
        idx_d   = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Dark every digit above the most significant nonzero one, except digit 0 and dp digits
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run    = zero_run && (act_dig_q[4*i +: 4] == 4'h0);
            lz_blank[i] = (i != 0) && zero_run && !act_dp_q[i];
        end
    end
`else
    assign lz_blank = '0;
`endif

    // Select the active-frame fields of the digit being scanned
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = act_dig_q[4*i +: 4];
                cur_dp    = act_dp_q[i];
                cur_blank = act_blank_q[i] || lz_blank[i];
            end
        end
    end

    // Pin values for the current slot; a disabled slot drives everything dark to avoid ghosting
    always_comb begin
        enabled = (phase <= act_bright_q) && !cur_blank;
        an_d    = '1;
        cath_d  = 8'hFF;
        if (enabled) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                an_d[i] = !(idx_q == IDX_W'(i));
            end
            cath_d = {seg_decode(cur_nib), ~cur_dp};
        end
    end

    // Free-running prescaler and digit index
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

    // Frame buffering: loads park in pending and only reach active at a wrap so a scan never mixes frames
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            act_dig_q     <= '0;
            act_dp_q      <= '0;
            act_blank_q   <= '0;
            act_bright_q  <= '0;
            pend_dig_q    <= '0;
            pend_dp_q     <= '0;
            pend_blank_q  <= '0;
            pend_bright_q <= '0;
            pend_valid_q  <= 1'b0;
        end else if (load && wrap) begin
            act_dig_q     <= digits_in;
            act_dp_q      <= dp_in;
            act_blank_q   <= blank_in;
            act_bright_q  <= brightness;
            pend_valid_q  <= 1'b0;
        end else if (load) begin
            pend_dig_q    <= digits_in;
            pend_dp_q     <= dp_in;
            pend_blank_q  <= blank_in;
            pend_bright_q <= brightness;
            pend_valid_q  <= 1'b1;
        end else if (wrap && pend_valid_q) begin
            act_dig_q     <= pend_dig_q;
            act_dp_q      <= pend_dp_q;
            act_blank_q   <= pend_blank_q;
            act_bright_q  <= pend_bright_q;
            pend_valid_q  <= 1'b0;
        end
    end

    // Register pin outputs and the frame wrap pulse
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            an_q   <= '1;
            cath_q <= 8'hFF;
            fd_q   <= 1'b0;
        end else begin
            an_q   <= an_d;
            cath_q <= cath_d;
            fd_q   <= wrap;
        end
    end

    assign an         = an_q;
    assign cathodes   = cath_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb/tb_ssd_scan_driver.sv - randomized model-checked bench for ssd_scan_driver
module tb_ssd_scan_driver;

    localparam int N     = 8;
    localparam int S     = 4;
    localparam int P     = 2;
    localparam int SLOT  = 1 << S;
    localparam int FRAME = N * SLOT;

    logic             board_clk = 1'b0;
    logic             Reset     = 1'b1;
    logic             load      = 1'b0;
    logic [4*N-1:0]   digits_in = '0;
    logic [N-1:0]     dp_in     = '0;
    logic [N-1:0]     blank_in  = '0;
    logic [P-1:0]     brightness = '0;
    logic [N-1:0]     an;
    logic [7:0]       cathodes;
    logic             frame_done;

    ssd_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV_BITS(S), .PWM_BITS(P)) dut (
        .board_clk  (board_clk),
        .Reset      (Reset),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .brightness (brightness),
        .an         (an),
        .cathodes   (cathodes),
        .frame_done (frame_done)
    );

    always #5 board_clk = ~board_clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [0:15];

    // Reference model: scan position is derived from elapsed cycles, frames as plain values
    int          t;
    logic [31:0] m_dig, p_dig;
    logic [7:0]  m_dp, p_dp, m_blank, p_blank;
    logic [1:0]  m_br, p_br;
    bit          p_valid;
    bit          lzb_on;
    int          an_low;
    int          fd_n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic model_reset();
        t = 0;
        m_dig = '0; m_dp = '0; m_blank = '0; m_br = '0;
        p_dig = '0; p_dp = '0; p_blank = '0; p_br = '0;
        p_valid = 0;
    endtask

    task automatic step();
        int presc, idx, msd;
        bit en, wrap;
        logic [3:0] nib;
        logic [7:0] e_an, e_cath;
        presc = t % SLOT;
        idx   = (t / SLOT) % N;
        msd   = 0;
        for (int i = 0; i < N; i++) if (((m_dig >> (4 * i)) & 32'hF) != 0) msd = i;
        nib = 4'((m_dig >> (4 * idx)) & 32'hF);
        en  = ((presc / (SLOT >> P)) <= int'(m_br)) && !m_blank[idx]
              && !(lzb_on && idx > msd && !m_dp[idx]);
        e_an   = en ? ~(8'h01 << idx) : 8'hFF;
        e_cath = en ? {seg_tab[nib], ~m_dp[idx]} : 8'hFF;
        wrap   = (presc == SLOT - 1) && (idx == N - 1);
        if (load && wrap) begin
            m_dig = digits_in; m_dp = dp_in; m_blank = blank_in; m_br = brightness;
            p_valid = 0;
        end else if (load) begin
            p_dig = digits_in; p_dp = dp_in; p_blank = blank_in; p_br = brightness;
            p_valid = 1;
        end else if (wrap && p_valid) begin
            m_dig = p_dig; m_dp = p_dp; m_blank = p_blank; m_br = p_br;
            p_valid = 0;
        end
        @(posedge board_clk);
        @(negedge board_clk);
        t++;
        check("an", 32'(an), 32'(e_an));
        check("cathodes", 32'(cathodes), 32'(e_cath));
        check("frame_done", 32'(frame_done), 32'(wrap));
        if (an != 8'hFF) an_low++;
        if (frame_done) fd_n++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic align();
        while ((t % FRAME) != 0) step();
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl,
                           input logic [1:0] br);
        digits_in = d; dp_in = dp; blank_in = bl; brightness = br;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic count_frame(input string tag, input int exp_low);
        an_low = 0;
        fd_n   = 0;
        run(FRAME);
        check({tag, "_an_low"}, 32'(an_low), 32'(exp_low));
        check({tag, "_frame_done"}, 32'(fd_n), 32'd1);
    endtask

    initial begin
        seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111; seg_tab[2]  = 7'b0010010;
        seg_tab[3]  = 7'b0000110; seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
        seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111; seg_tab[8]  = 7'b0000000;
        seg_tab[9]  = 7'b0000100; seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
        seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1000010; seg_tab[14] = 7'b0110000;
        seg_tab[15] = 7'b0111000;
`ifdef LEADING_ZERO_BLANK_EN
        lzb_on = 1;
`else
        lzb_on = 0;
`endif
        an_low = 0;
        fd_n   = 0;
        model_reset();

        // Reset state
        repeat (3) @(negedge board_clk);
        check("rst_an", 32'(an), 32'hFF);
        check("rst_cathodes", 32'(cathodes), 32'hFF);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        Reset = 1'b0;
        run(40);

        // A5 at full brightness; spot-check decoded patterns from the table directly
        do_load(32'h0000_00A5, 8'h00, 8'h00, 2'b11);
        align();
        step();
        check("digit0_cath", 32'(cathodes), 32'h49);
        run(SLOT - 1);
        step();
        check("digit1_cath", 32'(cathodes), 32'h11);
        align();
        count_frame("a5", lzb_on ? 2 * SLOT : FRAME);

        // Mid-frame load, then load exactly on the wrap-tick cycle
        run(40);
        do_load(32'h1111_1111, 8'h00, 8'h00, 2'b11);
        run(30);
        while ((t % FRAME) != FRAME - 1) step();
        do_load(32'h2222_2222, 8'h00, 8'h00, 2'b11);
        run(20);

        // Brightness duty
        do_load(32'h1234_5678, 8'h00, 8'h00, 2'b00);
        align();
        count_frame("duty0", N * (SLOT / 4));
        do_load(32'h1234_5678, 8'h00, 8'h00, 2'b01);
        align();
        count_frame("duty1", N * (SLOT / 2));

        // Blanking and decimal point
        do_load(32'h8765_4321, 8'h01, 8'h02, 2'b11);
        align();
        count_frame("blank", FRAME - SLOT);

        // Leading-zero case
        do_load(32'h0000_0105, 8'h00, 8'h00, 2'b11);
        align();
        count_frame("lzb", lzb_on ? 3 * SLOT : FRAME);

        // Asynchronous reset mid-frame
        run(50);
        #2 Reset = 1'b1;
        #1;
        check("async_rst_an", 32'(an), 32'hFF);
        check("async_rst_cathodes", 32'(cathodes), 32'hFF);
        @(negedge board_clk);
        model_reset();
        Reset = 1'b0;
        run(30);

        // Randomized loads, some aimed at the wrap tick, some doubled before a wrap
        for (int k = 0; k < 30; k++) begin
            run($urandom_range(0, 200));
            if ($urandom_range(0, 3) == 0) begin
                while ((t % FRAME) != FRAME - 1) step();
            end
            do_load($urandom, 8'($urandom), 8'($urandom_range(0, 3) == 0 ? $urandom : 0),
                    2'($urandom));
        end
        run(2 * FRAME);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
